denise_rga_sequencer: RTL and testbench

- Front end of Denise's register bus: samples the RGA register-address bus once per bus clock (CCK) and classifies each slot as idle, read, or write.
- Generates the one-slot-delayed ("_p1") strobes for the collision unit: CLXCON write, CLXDAT read/clear.
- Forwards a generic write port to the other register files in the chip.
- Owns the read-data mux and the data-bus output enable toward the external DB pins.

---
 rtl/denise_rga_sequencer_if.sv | 27 ++
 rtl/denise_rga_sequencer.sv | 72 +++++++
 tb/tb_denise_rga_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/denise_rga_sequencer_if.sv
// Register-bus signal bundle between the RGA bus side and the Denise slot sequencer.
// The master side drives the address/data slot; the slave side returns strobes and read data.
interface denise_rga_sequencer_if;
    logic        cck_pos_edge;
    logic [7:0]  rga;
    logic [15:0] db_in;
    logic [15:0] clx_db_in;
    logic        w_wregs_clx_p1;
    logic        w_rregs_clx_p1;
    logic        reg_wr_p1;
    logic [7:0]  reg_addr_p1;
    logic [15:0] reg_wdata_p1;
    logic [15:0] db_out;
    logic        db_oe;

    modport master (
        output cck_pos_edge, rga, db_in, clx_db_in,
        input  w_wregs_clx_p1, w_rregs_clx_p1, reg_wr_p1, reg_addr_p1,
               reg_wdata_p1, db_out, db_oe
    );

    modport slave (
        input  cck_pos_edge, rga, db_in, clx_db_in,
        output w_wregs_clx_p1, w_rregs_clx_p1, reg_wr_p1, reg_addr_p1,
               reg_wdata_p1, db_out, db_oe
    );
endinterface

// File: rtl/denise_rga_sequencer.sv
// Denise register-bus front end: classifies each CCK slot from RGA and produces
// the one-slot-delayed write/read strobes, the read-data mux and the DB output enable.
module denise_rga_sequencer #(
    parameter logic [15:0] DENISE_ID     = 16'h00FC,
    parameter logic [7:0]  RGA_IDLE      = 8'hFF,
    parameter logic [7:0]  ADDR_CLXDAT   = 8'h07,
    parameter logic [7:0]  ADDR_CLXCON   = 8'h4C,
    parameter logic [7:0]  ADDR_DENISEID = 8'h3E,
    parameter logic [7:0]  FOREIGN_LIMIT = 8'h10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    denise_rga_sequencer_if.slave         bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_CLX,
        ST_RD_ID
    } slot_t;

    slot_t state;
    slot_t slot_class;

    // Priority decode: idle code first, then the two reads Denise answers,
    // then low addresses owned by other chips, everything else is a write.
    always_comb begin
        slot_class = ST_IDLE;
        if (bus.rga == RGA_IDLE)
            slot_class = ST_IDLE;
        else if (bus.rga == ADDR_CLXDAT)
            slot_class = ST_RD_CLX;
        else if (bus.rga == ADDR_DENISEID)
            slot_class = ST_RD_ID;
        else if (bus.rga < FOREIGN_LIMIT)
            slot_class = ST_IDLE;
        else
            slot_class = ST_WR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            bus.reg_addr_p1    <= 8'h00;
            bus.reg_wdata_p1   <= 16'h0000;
            bus.reg_wr_p1      <= 1'b0;
            bus.w_wregs_clx_p1 <= 1'b0;
            bus.w_rregs_clx_p1 <= 1'b0;
            bus.db_oe          <= 1'b0;
        end else if (bus.cck_pos_edge) begin
            state              <= slot_class;
            bus.reg_addr_p1    <= bus.rga;
            bus.reg_wdata_p1   <= bus.db_in;
            bus.reg_wr_p1      <= (slot_class == ST_WR);
            bus.w_wregs_clx_p1 <= (slot_class == ST_WR) && (bus.rga == ADDR_CLXCON);
            bus.w_rregs_clx_p1 <= (slot_class == ST_RD_CLX);
            bus.db_oe          <= (slot_class == ST_RD_CLX) || (slot_class == ST_RD_ID);
        end
    end

    // CLXDAT bit 15 is unimplemented in the collision unit and always reads as 1.
    always_comb begin
        bus.db_out = 16'h0000;
        case (state)
            ST_RD_CLX: bus.db_out = {1'b1, bus.clx_db_in[14:0]};
            ST_RD_ID:  bus.db_out = DENISE_ID;
            default:   bus.db_out = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_denise_rga_sequencer.sv
// Self-checking bench for denise_rga_sequencer: directed scenarios followed by random
// slots, all compared against a slot-rule model driven by the last accepted RGA sample.
module tb_denise_rga_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0]  m_rga;
    logic [15:0] m_db;

    denise_rga_sequencer_if bus ();

    denise_rga_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    // Drive one slot at the falling edge; the model only accepts it on a real CCK edge out of reset.
    task automatic apply_stimulus(input logic [7:0] r, input logic [15:0] d, input bit pulse);
        @(negedge clk);
        bus.rga          = r;
        bus.db_in        = d;
        bus.cck_pos_edge = pulse;
        @(posedge clk);
        if (pulse && rst_n) begin
            m_rga = r;
            m_db  = d;
        end
        #1;
        bus.cck_pos_edge = 1'b0;
    endtask

    task automatic check_output(input string tag);
        bit          is_clx;
        bit          is_id;
        bit          is_wr;
        logic [15:0] exp_db;
        is_clx = (m_rga == 8'h07);
        is_id  = (m_rga == 8'h3E);
        is_wr  = (m_rga >= 8'h10) && (m_rga != 8'hFF) && !is_id;
        exp_db = is_clx ? (bus.clx_db_in | 16'h8000) : (is_id ? 16'h00FC : 16'h0000);
        check_val({tag, ".reg_wr"},   bus.reg_wr_p1,      is_wr);
        check_val({tag, ".wclx"},     bus.w_wregs_clx_p1, is_wr && (m_rga == 8'h4C));
        check_val({tag, ".rclx"},     bus.w_rregs_clx_p1, is_clx);
        check_val({tag, ".db_oe"},    bus.db_oe,          is_clx || is_id);
        check_val({tag, ".db_out"},   bus.db_out,         exp_db);
        check_val({tag, ".addr"},     bus.reg_addr_p1,    m_rga);
        check_val({tag, ".wdata"},    bus.reg_wdata_p1,   m_db);
        check_val({tag, ".excl"},     bus.db_oe && bus.reg_wr_p1, 1'b0);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        m_rga            = 8'h00;
        m_db             = 16'h0000;
        rst_n            = 1'b0;
        bus.cck_pos_edge = 1'b0;
        bus.rga          = 8'h4C;
        bus.db_in        = 16'hFFFF;
        bus.clx_db_in    = 16'h0000;

        // Reset held across five CCK edges with a CLXCON write on the bus.
        for (int i = 0; i < 5; i++) apply_stimulus(8'h4C, 16'hFFFF, 1'b1);
        check_output("reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(8'h4C, 16'hFFFF, 1'b1);
        check_output("post_reset_wr");

        // CLXCON write then idle.
        apply_stimulus(8'h4C, 16'hF0C3, 1'b1);
        check_output("clxcon_wr");
        apply_stimulus(8'hFF, 16'h0000, 1'b1);
        check_output("idle_after_wr");

        // Back-to-back CLXDAT reads, collision data changing between slots.
        bus.clx_db_in = 16'h0201;
        apply_stimulus(8'h07, 16'h0000, 1'b1);
        check_output("clxdat_rd1");
        bus.clx_db_in = 16'hF00F;
        apply_stimulus(8'h07, 16'h0000, 1'b1);
        check_output("clxdat_rd2");

        // DENISEID and a foreign read.
        apply_stimulus(8'h3E, 16'h5555, 1'b1);
        check_output("deniseid_rd");
        apply_stimulus(8'h05, 16'hAAAA, 1'b1);
        check_output("foreign_rd");

        // Interleaved generic write / read / CLXCON write / idle.
        bus.clx_db_in = 16'h1357;
        apply_stimulus(8'h80, 16'h1234, 1'b1);
        check_output("il_wr");
        apply_stimulus(8'h07, 16'h0000, 1'b1);
        check_output("il_rd");
        apply_stimulus(8'h4C, 16'h00A5, 1'b1);
        check_output("il_clxcon");
        apply_stimulus(8'hFF, 16'h0000, 1'b1);
        check_output("il_idle");

        // Stall mid-write: bus changes but no CCK edge arrives for ten clocks.
        apply_stimulus(8'h80, 16'hBEEF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(8'($urandom), 16'($urandom), 1'b0);
            check_output("stall");
        end

        // Asynchronous reset landing in the middle of a CLXDAT read slot.
        apply_stimulus(8'h07, 16'h0000, 1'b1);
        check_output("pre_abort_rd");
        #2;
        rst_n = 1'b0;
        m_rga = 8'h00;
        m_db  = 16'h0000;
        #1;
        check_output("async_abort");
        @(negedge clk);
        rst_n = 1'b1;

        // Random slots with random CCK gaps.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] r;
            case ($urandom_range(0, 7))
                0: r = 8'hFF;
                1: r = 8'h07;
                2: r = 8'h3E;
                3: r = 8'h4C;
                4: r = 8'($urandom_range(0, 15));
                default: r = 8'($urandom);
            endcase
            bus.clx_db_in = 16'($urandom);
            apply_stimulus(r, 16'($urandom), ($urandom_range(0, 3) != 0));
            check_output("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
